// File: rtl/fmap_channel_packer.sv
// Collects NUMBER_OF_CHANNEL serial planes from the conv/ReLU stream, then replays
// them one pixel per beat with all channels side by side on a flattened bus.
module fmap_channel_packer #(
  parameter int DATA_WIDTH        = 32,
  parameter int IMAGE_WIDTH       = 3,
  parameter int NUMBER_OF_CHANNEL = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_valid,
  input  logic [DATA_WIDTH-1:0]                   i_data,
  output logic                                    i_ready,
  output logic [DATA_WIDTH*NUMBER_OF_CHANNEL-1:0] o_data,
  output logic                                    o_valid,
  input  logic                                    i_out_ready,
  output logic                                    o_done,
  output logic                                    o_overflow
);

  localparam int N     = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int NC    = NUMBER_OF_CHANNEL;
  localparam int DEPTH = N * NC;
  localparam int PW    = (N > 1) ? $clog2(N) : 1;
  localparam int CW    = (NC > 1) ? $clog2(NC) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Handshakes: a sample moves on an edge with i_valid & i_ready; a packed pixel
  // moves on an edge with o_valid & i_out_ready, and o_data is held until then.
  logic [1:0]               state;
  logic [PW-1:0]            wr_pix;
  logic [PW-1:0]            rd_pix;
  logic [PW-1:0]            nxt_pix;
  logic [CW-1:0]            wr_ch;
  logic [AW-1:0]            wr_addr;
  logic [DATA_WIDTH*NC-1:0] nxt_data;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  assign wr_addr = AW'(wr_ch) * AW'(N) + AW'(wr_pix);

  // Pixel to present after the next edge: pixel 0 when arming, else the successor.
  always_comb begin
    nxt_pix  = (state == ARM) ? '0 : rd_pix + PW'(1);
    nxt_data = '0;
    for (int k = 0; k < NC; k++) begin
      nxt_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[AW'(k * N) + AW'(nxt_pix)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == FILL && i_valid) begin
      mem[wr_addr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      wr_pix     <= '0;
      wr_ch      <= '0;
      rd_pix     <= '0;
      i_ready    <= 1'b1;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_valid && !i_ready) begin
        o_overflow <= 1'b1;
      end
      case (state)
        FILL: begin
          if (i_valid) begin
            if (wr_pix == PW'(N - 1)) begin
              wr_pix <= '0;
              if (wr_ch == CW'(NC - 1)) begin
                wr_ch   <= '0;
                state   <= ARM;
                i_ready <= 1'b0;
              end else begin
                wr_ch <= wr_ch + CW'(1);
              end
            end else begin
              wr_pix <= wr_pix + PW'(1);
            end
          end
        end
        ARM: begin
          o_valid <= 1'b1;
          o_data  <= nxt_data;
          rd_pix  <= '0;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (o_valid && i_out_ready) begin
            if (rd_pix == PW'(N - 1)) begin
              o_valid <= 1'b0;
              o_data  <= '0;
              o_done  <= 1'b1;
              i_ready <= 1'b1;
              rd_pix  <= '0;
              state   <= FILL;
            end else begin
              rd_pix <= nxt_pix;
              o_data <= nxt_data;
            end
          end
        end
        default: begin
          state   <= FILL;
          i_ready <= 1'b1;
          o_valid <= 1'b0;
          o_data  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmap_channel_packer.sv
// Bench for fmap_channel_packer (2 channels of 3x3): frame-level queue model,
// directed frames from the test plan plus randomized data, gaps and backpressure.
module tb_fmap_channel_packer;

  localparam int DW = 32;
  localparam int IW = 3;
  localparam int NC = 2;
  localparam int N  = IW * IW;
  localparam int FR = N * NC;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic [DW-1:0]    i_data;
  logic             i_ready;
  logic [DW*NC-1:0] o_data;
  logic             o_valid;
  logic             i_out_ready;
  logic             o_done;
  logic             o_overflow;

  fmap_channel_packer #(
    .DATA_WIDTH(DW),
    .IMAGE_WIDTH(IW),
    .NUMBER_OF_CHANNEL(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .i_data(i_data),
    .i_ready(i_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_out_ready(i_out_ready),
    .o_done(o_done),
    .o_overflow(o_overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: accepted samples of the current frame and the beats still owed
  logic [DW-1:0]    in_q[$];
  logic [DW*NC-1:0] exp_q[$];
  bit m_ready, m_valid, m_done, m_ovf, m_arm;
  int sent;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // one clock: update the model at the edge, then compare all outputs mid-cycle
  task automatic step();
    logic [DW*NC-1:0] b;
    @(posedge clk);
    if (rst) begin
      in_q.delete();
      exp_q.delete();
      m_ready = 1'b1;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_ovf   = 1'b0;
      m_arm   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (i_valid && !m_ready) m_ovf = 1'b1;
      if (m_valid && i_out_ready) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_valid = 1'b0;
          m_done  = 1'b1;
          m_ready = 1'b1;
        end
      end else if (m_arm) begin
        m_arm   = 1'b0;
        m_valid = 1'b1;
      end else if (i_valid && m_ready) begin
        in_q.push_back(i_data);
        sent++;
        if (in_q.size() == FR) begin
          for (int p = 0; p < N; p++) begin
            for (int k = 0; k < NC; k++) b[k*DW +: DW] = in_q[k*N + p];
            exp_q.push_back(b);
          end
          in_q.delete();
          m_ready = 1'b0;
          m_arm   = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("i_ready", 64'(i_ready), 64'(m_ready));
    check("o_valid", 64'(o_valid), 64'(m_valid));
    check("o_done", 64'(o_done), 64'(m_done));
    check("o_overflow", 64'(o_overflow), 64'(m_ovf));
    check("o_data", 64'(o_data), m_valid ? 64'(exp_q[0]) : 64'd0);
  endtask

  // driver: one frame in, replay out.
  // gap: 0 continuous, 1 every other cycle, 2 random; bp: 0 none, 1 five-cycle stall at beat 3, 2 random
  task automatic run_frame(input logic [DW-1:0] base, input bit rnd_data, input int gap,
                           input int bp, input bit ovf, input int rst_beat, output int fill_cyc);
    int  cyc = 0;
    int  stall = 0;
    int  beat;
    bit  done = 1'b0;
    bit  ovf_sent = 1'b0;
    sent = 0;
    fill_cyc = 0;
    while (!done && cyc < 400) begin
      i_valid     = 1'b0;
      i_data      = '0;
      i_out_ready = 1'b1;
      if (sent < FR && (gap == 0 || (gap == 1 && cyc % 2 == 0) ||
                        (gap == 2 && $urandom_range(0, 1) == 1))) begin
        i_valid = 1'b1;
        i_data  = rnd_data ? DW'($urandom) : base + DW'(sent);
      end
      beat = m_valid ? N - exp_q.size() : -1;
      if (ovf && beat == 2 && !ovf_sent) begin
        i_valid  = 1'b1;
        i_data   = 32'hDEADBEEF;
        ovf_sent = 1'b1;
      end
      if (bp == 1 && beat == 3 && stall < 5) begin
        i_out_ready = 1'b0;
        stall++;
      end else if (bp == 2) begin
        i_out_ready = ($urandom_range(0, 3) != 0);
      end
      if (rst_beat >= 0 && beat == rst_beat) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        done = 1'b1;
      end else begin
        step();
        cyc++;
        if (fill_cyc == 0 && !i_ready) fill_cyc = cyc;
        if (m_done) done = 1'b1;
      end
    end
    if (!done) check("frame_timeout", 64'd0, 64'd1);
    i_valid = 1'b0;
  endtask

  initial begin
    int fc;
    rst         = 1'b1;
    i_valid     = 1'b0;
    i_data      = '0;
    i_out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    run_frame(32'h1, 1'b0, 0, 0, 1'b0, -1, fc);
    check("fill_cyc_cont", 64'(fc), 64'd18);
    run_frame(32'h1, 1'b0, 1, 0, 1'b0, -1, fc);
    check("fill_cyc_gap", 64'(fc), 64'd35);
    run_frame(32'h1, 1'b0, 0, 1, 1'b0, -1, fc);
    run_frame(32'h1, 1'b0, 0, 0, 1'b1, -1, fc);
    run_frame(32'h201, 1'b0, 0, 0, 1'b0, -1, fc);
    run_frame(32'h1, 1'b0, 0, 0, 1'b0, 4, fc);
    run_frame(32'h101, 1'b0, 0, 0, 1'b0, -1, fc);
    run_frame(32'h301, 1'b0, 0, 0, 1'b0, -1, fc);
    for (int f = 0; f < 6; f++) begin
      run_frame(32'h0, 1'b1, 2, 2, (f == 2), -1, fc);
    end
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fmap_channel_packer.md
Name: fmap_channel_packer

Overview:
- Sink for the serial ReLU output stream of the 3D convolution block. That block emits one output channel (plane) at a time, in raster order.
- Buffers NUMBER_OF_CHANNEL planes in a register array, then replays them channel-parallel, one pixel per beat, on a flattened bus.
- This is the pixel-parallel multi-channel format the next conv layer consumes, so the block is the writer-to-reader turnaround between layers.

Parameters:
- DATA_WIDTH, 32, width of one fp32 sample.
- IMAGE_WIDTH, 3, side length of each incoming plane; N = IMAGE_WIDTH**2 pixels per plane.
- NUMBER_OF_CHANNEL, 4, number of planes collected before replay.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input sample valid.
- i_data  in  DATA_WIDTH  input sample, plane-major then raster order.
- i_ready  out  1  block accepts input (high only in FILL).
- o_data  out  DATA_WIDTH*NUMBER_OF_CHANNEL  packed pixel; channel k at bits [DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k].
- o_valid  out  1  o_data valid.
- i_out_ready  in  1  downstream accepts o_data.
- o_done  out  1  one-cycle pulse after last replay beat accepted.
- o_overflow  out  1  sticky: a sample was presented while i_ready=0.

Behaviour:
- Reset (rst=1 at edge, takes priority over everything):
  - state=FILL, wr_pix=0, wr_ch=0, rd_pix=0.
  - i_ready=1, o_valid=0, o_data=0, o_done=0, o_overflow=0.
  - Buffer contents are don't-care. Reset mid-FILL or mid-DRAIN aborts; partial data is discarded.
- Storage: register array of NUMBER_OF_CHANNEL*N entries, address = ch*N + pix. Write is synchronous; read is combinational.
- States: FILL, ARM, DRAIN.
- FILL:
  - i_ready=1. Each edge with i_valid=1 writes i_data to mem[wr_ch*N+wr_pix] and advances wr_pix.
  - wr_pix wraps N-1 -> 0 and increments wr_ch.
  - When the write at wr_ch=NC-1, wr_pix=N-1 occurs: state<=ARM, i_ready<=0, wr counters cleared.
  - i_valid=0 cycles are gaps; no state change.
- ARM: one cycle. o_valid<=1, o_data<=pixel 0 of all channels, state<=DRAIN, rd_pix=0.
- DRAIN:
  - o_valid held 1; o_data held stable while i_out_ready=0.
  - On an edge with o_valid&i_out_ready and rd_pix<N-1: rd_pix++, o_data<=pixel rd_pix+1. Back-to-back, one beat per cycle.
  - On the handshake with rd_pix=N-1: o_valid<=0, o_data<=0, o_done<=1 for exactly one cycle, state<=FILL, i_ready<=1, rd_pix=0.
- Latency:
  - Final input accepted at edge E0; ARM during E0..E1; o_valid first high after E1 (1 idle cycle).
  - Full replay with i_out_ready held high: N cycles.
  - i_ready returns high in the same cycle o_done is high; input may be accepted at the next edge.
- Overflow: i_valid=1 while i_ready=0 (ARM/DRAIN) drops the sample and sets o_overflow<=1. Cleared only by rst.
- Widths: data passes bit-exact, with no arithmetic or sign handling. Counters are sized $clog2 of their range, minimum 1 bit.
- Degenerate: IMAGE_WIDTH=1 gives N=1, and DRAIN lasts one beat. NUMBER_OF_CHANNEL=1 gives a pure buffer-and-replay.

Test Plan:
- DW=32, IW=3, NC=2; feed 18 samples 0x00000001..0x00000012 with i_valid continuous, i_out_ready=1.
  - Response: i_ready drops after sample 18.
  - Two cycles later, beat 0: o_data = {0x0000000A, 0x00000001}; beat 8: {0x00000012, 0x00000009}.
  - 9 consecutive beats, then o_done=1 for 1 cycle.
- Same stream with i_valid toggling every other cycle -> identical output; FILL takes 35 cycles.
- During DRAIN, hold i_out_ready=0 for 5 cycles at beat 3 -> o_valid stays 1 and o_data stays {0x0000000D, 0x00000004}; resumes at beat 4 with no loss.
- Assert i_valid with 0xDEADBEEF during DRAIN -> o_overflow=1 and stays 1 through the next frame; replayed data unchanged; rst clears it.
- Assert rst at beat 4 of DRAIN -> next cycle: o_valid=0, o_data=0, i_ready=1. A new 18-sample frame 0x101..0x112 then replays correctly, with beat 0 = {0x0000010A, 0x00000101}.
- Two frames back-to-back, with input resumed the edge after o_done -> second frame is accepted without loss and replayed correctly.
